// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, types and helpers for the VGA palette scaler
package vga_pkg;
  localparam int VGA_H_VIS = 640, VGA_H_FP = 16, VGA_H_SYNC = 96, VGA_H_BP = 48;
  localparam int VGA_V_VIS = 480, VGA_V_FP = 10, VGA_V_SYNC = 2, VGA_V_BP = 33;
  localparam int R_MSB = 15, R_LSB = 11, G_MSB = 10, G_LSB = 5, B_MSB = 4, B_LSB = 0;
  localparam logic [1:0] SCALE_1X = 2'd0, SCALE_2X = 2'd1, SCALE_4X = 2'd2;
  localparam logic [15:0][15:0] DEF_PAL = {
    16'hFFFF, 16'hFFE0, 16'hF81F, 16'hF800, 16'h07FF, 16'h07E0, 16'h001F, 16'hC618,
    16'h7BEF, 16'h8400, 16'h8010, 16'h8000, 16'h0410, 16'h0400, 16'h0010, 16'h0000};
  typedef struct packed {
    logic vis;
    logic img;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    return sel == SCALE_2X ? 2'd1 : sel == SCALE_4X ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/vga_palette_scaler_if.sv
// vga_palette_scaler_if: synchronous image memory read port
interface vga_palette_scaler_if #(
  parameter int AW = 17,
  parameter int BPP = 4
);
  logic [AW-1:0] mem_addr;
  logic [BPP-1:0] mem_q;
  modport master (output mem_addr, input mem_q);
  modport slave (input mem_addr, output mem_q);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: pixel-tick divider, h/v counters and raw sync/visible flags
module vga_timing
  import vga_pkg::*;
#(
  parameter int DIV = 4,
  parameter int H_VIS = VGA_H_VIS, H_FP = VGA_H_FP, H_SYNC = VGA_H_SYNC, H_BP = VGA_H_BP,
  parameter int V_VIS = VGA_V_VIS, V_FP = VGA_V_FP, V_SYNC = VGA_V_SYNC, V_BP = VGA_V_BP,
  parameter int HW = 10,
  parameter int VW = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic ce,
  output logic vis,
  output logic hs_act,
  output logic vs_act,
  output logic first,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v
);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] D_MAX = DW'(DIV - 1);
  localparam logic [HW-1:0] H_MAX = HW'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_V = HW'(H_VIS), H_S0 = HW'(H_VIS + H_FP), H_S1 = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_V = VW'(V_VIS), V_S0 = VW'(V_VIS + V_FP), V_S1 = VW'(V_VIS + V_FP + V_SYNC - 1);
  logic [DW-1:0] div;
  assign ce = div == '0;
  assign vis = h < H_V && v < V_V;
  assign hs_act = h >= H_S0 && h <= H_S1;
  assign vs_act = v >= V_S0 && v <= V_S1;
  assign first = h == '0 && v == '0;
  // free-running divider; raster counters step on each pixel tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      h <= '0;
      v <= '0;
    end else begin
      div <= div == D_MAX ? '0 : div + 1'b1;
      if (ce) begin
        h <= h == H_MAX ? '0 : h + 1'b1;
        if (h == H_MAX) v <= v == V_MAX ? '0 : v + 1'b1;
      end
    end
endmodule

// File: rtl/vga_palette_scaler.sv
// vga_palette_scaler: VGA output stage with scaled image fetch and RGB565 palette
module vga_palette_scaler
  import vga_pkg::*;
#(
  parameter int DIV = 4,
  parameter int RD_LAT = 1,
  parameter int H_VIS = VGA_H_VIS, H_FP = VGA_H_FP, H_SYNC = VGA_H_SYNC, H_BP = VGA_H_BP,
  parameter int V_VIS = VGA_V_VIS, V_FP = VGA_V_FP, V_SYNC = VGA_V_SYNC, V_BP = VGA_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int BPP = 4,
  parameter int AW = $clog2(IMG_W * IMG_H)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [1:0] scale_sel,
  input  logic [15:0] border,
  input  logic pal_we,
  input  logic [BPP-1:0] pal_addr,
  input  logic [15:0] pal_data,
  vga_palette_scaler_if.master bus,
  output logic [4:0] vga_red,
  output logic [5:0] vga_green,
  output logic [4:0] vga_blue,
  output logic vga_hs,
  output logic vga_vs,
  output logic frame_start
);
  localparam int HW = $clog2(H_VIS + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_VIS + V_FP + V_SYNC + V_BP);
  localparam logic [HW-1:0] IW = HW'(IMG_W);
  localparam logic [VW-1:0] IH = VW'(IMG_H);
  localparam logic [AW-1:0] IW_A = AW'(IMG_W);
  typedef logic [15:0] pal_t [2**BPP];
  if (DIV <= RD_LAT) begin : g_bad_div
    $error("DIV must exceed RD_LAT so mem_q settles within one pixel tick");
  end
  function automatic pal_t pal_default();
    for (int i = 0; i < 2**BPP; i++) pal_default[i] = DEF_PAL[4'(i)];
  endfunction
  logic ce, vis, hs_act, vs_act, first, in_img;
  logic [HW-1:0] h, hx;
  logic [VW-1:0] v, vy;
  logic [1:0] sh, sh_q;
  logic [AW-1:0] addr_n;
  logic [BPP-1:0] q2;
  logic [15:0] rgb;
  flags_t p1, p2;
  pal_t pal = pal_default();
  vga_timing #(
    .DIV(DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .ce(ce), .vis(vis), .hs_act(hs_act), .vs_act(vs_act),
    .first(first), .h(h), .v(v)
  );
  assign sh = first ? scale_shift(scale_sel) : sh_q;
  assign hx = h >> sh;
  assign vy = v >> sh;
  assign in_img = vis && hx < IW && vy < IH;
  assign addr_n = in_img ? AW'(vy) * IW_A + AW'(hx) : '0;
  assign vga_red = rgb[R_MSB:R_LSB];
  assign vga_green = rgb[G_MSB:G_LSB];
  assign vga_blue = rgb[B_MSB:B_LSB];
  // palette RAM writes on any clock, so software updates need no pixel tick
  always_ff @(posedge clk)
    if (pal_we) pal[pal_addr] <= pal_data;
  // three-tick pipeline: address/flags, memory sample, colour mux with delayed syncs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q <= '0;
      bus.mem_addr <= '0;
      p1 <= '0;
      p2 <= '0;
      q2 <= '0;
      rgb <= '0;
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce && p2.fs;
      if (ce) begin
        if (first) sh_q <= sh;
        bus.mem_addr <= addr_n;
        p1 <= {vis, in_img, hs_act, vs_act, first};
        q2 <= bus.mem_q;
        p2 <= p1;
        rgb <= !p2.vis ? '0 : !p2.img ? border : pal[q2];
        vga_hs <= p2.hs ? HS_POL : ~HS_POL;
        vga_vs <= p2.vs ? VS_POL : ~VS_POL;
      end
    end
endmodule

// File: tb/tb_vga_palette_scaler.sv
// tb_vga_palette_scaler: randomized raster run against a frame-position reference model
module tb_vga_palette_scaler;
  localparam int DIV = 4, HV = 16, HF = 2, HS = 3, HB = 3, VV = 10, VF = 1, VS = 2, VB = 2;
  localparam int IW = 6, IH = 4, HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT, FCLK = FRAME * DIV, AW = $clog2(IW * IH);
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] scale_sel = 2'd0;
  logic [15:0] border = 16'hF800;
  logic pal_we = 1'b0;
  logic [3:0] pal_addr = '0;
  logic [15:0] pal_data = '0;
  logic [4:0] vga_red, vga_blue;
  logic [5:0] vga_green;
  logic vga_hs, vga_vs, frame_start;
  logic [3:0] img [32];
  logic [15:0] pal_m [16];
  int s_of [16];
  int c, checks, errors;
  logic [15:0] e_rgb;
  logic e_hs, e_vs, e_fs;
  logic [AW-1:0] e_addr;
  vga_palette_scaler_if #(.AW(AW), .BPP(4)) bus();
  vga_palette_scaler #(
    .DIV(DIV), .RD_LAT(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
    .IMG_W(IW), .IMG_H(IH), .BPP(4), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scale_sel(scale_sel), .border(border), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .bus(bus), .vga_red(vga_red),
    .vga_green(vga_green), .vga_blue(vga_blue), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bus.mem_q <= img[bus.mem_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, c, got, exp);
    end
  endtask
  function automatic int scale_of(input logic [1:0] sel);
    return sel == 2'd1 ? 2 : sel == 2'd2 ? 4 : 1;
  endfunction
  function automatic int addr_of(input int p);
    int h = p % HT, v = (p / HT) % VT, s = s_of[(p / FRAME) % 16];
    return (h < HV && v < VV && h < IW * s && v < IH * s) ? (v / s) * IW + h / s : 0;
  endfunction
  function automatic logic [15:0] color_of(input int p);
    int h = p % HT, v = (p / HT) % VT, s = s_of[(p / FRAME) % 16];
    if (!(h < HV && v < VV)) return 16'h0000;
    if (!(h < IW * s && v < IH * s)) return border;
    return pal_m[img[(v / s) * IW + h / s]];
  endfunction
  task automatic expect_reset();
    e_rgb = '0;
    e_hs = 1'b1;
    e_vs = 1'b1;
    e_fs = 1'b0;
    e_addr = '0;
  endtask
  task automatic check_outputs(input string pfx);
    check({pfx, "rgb"}, 32'({vga_red, vga_green, vga_blue}), 32'(e_rgb));
    check({pfx, "hs"}, 32'(vga_hs), 32'(e_hs));
    check({pfx, "vs"}, 32'(vga_vs), 32'(e_vs));
    check({pfx, "frame_start"}, 32'(frame_start), 32'(e_fs));
    check({pfx, "mem_addr"}, 32'(bus.mem_addr), 32'(e_addr));
  endtask
  task automatic tick();
    int k, p, h, v;
    @(posedge clk);
    e_fs = 1'b0;
    if (c % DIV == 0) begin
      k = c / DIV;
      if (k % FRAME == 0) s_of[(k / FRAME) % 16] = scale_of(scale_sel);
      e_addr = AW'(addr_of(k));
      if (k >= 2) begin
        p = k - 2;
        h = p % HT;
        v = (p / HT) % VT;
        e_rgb = color_of(p);
        e_hs = !(h >= HV + HF && h < HV + HF + HS);
        e_vs = !(v >= VV + VF && v < VV + VF + VS);
        e_fs = p % FRAME == 0;
      end
    end
    if (pal_we) pal_m[pal_addr] = pal_data;
    c++;
    @(negedge clk);
    check_outputs("");
  endtask
  task automatic run_until(input int cyc);
    while (c < cyc) tick();
  endtask
  task automatic pal_write(input logic [3:0] a, input logic [15:0] d, input bit on_tick);
    while (on_tick && c % DIV != 0) tick();
    pal_we = 1'b1;
    pal_addr = a;
    pal_data = d;
    tick();
    pal_we = 1'b0;
  endtask
  task automatic release_reset();
    rst_n = 1'b1;
    c = 0;
    foreach (s_of[i]) s_of[i] = 1;
    expect_reset();
  endtask
  initial begin
    checks = 0;
    errors = 0;
    c = 0;
    pal_m = '{16'h0000, 16'h0010, 16'h0400, 16'h0410, 16'h8000, 16'h8010, 16'h8400, 16'h7BEF,
              16'hC618, 16'h001F, 16'h07E0, 16'h07FF, 16'hF800, 16'hF81F, 16'hFFE0, 16'hFFFF};
    foreach (img[i]) img[i] = 4'($urandom_range(0, 15));
    img[0] = 4'hF;
    img[7] = 4'h3;
    img[8] = 4'h3;
    img[13] = 4'h7;
    repeat (3) @(negedge clk);
    expect_reset();
    check_outputs("rst_");
    release_reset();
    run_until(FCLK + 60);
    scale_sel = 2'd1;
    run_until(2 * FCLK + 3 * HT * DIV);
    pal_write(4'h3, 16'h07E0, 1'b1);
    border = 16'($urandom);
    run_until(2 * FCLK + 4 * HT * DIV + 2);
    pal_write(4'h3, 16'h07E0, 1'b0);
    pal_write(4'($urandom_range(4, 14)), 16'($urandom), 1'b0);
    scale_sel = 2'd2;
    run_until(3 * FCLK + 40);
    border = 16'hF800;
    scale_sel = 2'd3;
    pal_write(4'hF, 16'($urandom), 1'b1);
    run_until(4 * FCLK + 7 * HT * DIV + 9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_reset();
    check_outputs("midrst_");
    repeat (2) @(negedge clk);
    check_outputs("midrst_hold_");
    scale_sel = 2'd1;
    release_reset();
    run_until(FCLK + 50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
